// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
//
// Bundle of every signal exchanged between the multi-cycle control unit and
// the shared datapath / unified memory port.
//
//   master : the control unit (drives datapath enables, samples IR/flags)
//   slave  : the datapath + memory side (drives opcode/zero/mem_ready)
//
// Signals
//   opcode     IR[6:0], valid from DECODE onward
//   zero       ALU zero flag
//   mem_ready  memory completes the current access this cycle
//   mem_req    memory access request
//   mem_we     write (1) / read (0) qualifier for mem_req
//   i_or_d     memory address select: 0 = PC, 1 = ALUOut
//   ir_write   load IR from memory read data
//   pc_write   PC update enable
//   pc_src     PC source: 0 = ALU result, 1 = ALUOut
//   alu_src_a  ALU A: 00 = PC, 01 = reg A, 10 = old PC
//   alu_src_b  ALU B: 00 = reg B, 01 = constant 4, 10 = immediate
//   alu_op     00 add, 01 sub, 10 R-funct, 11 I-funct (upper bits always 0)
//   reg_write  register-file write enable
//   mem_to_reg write-back source: 1 = MDR, 0 = ALUOut
//   illegal    sticky: unsupported opcode decoded
//   fault      sticky: memory watchdog expired
//   state_o    current state encoding, for debug
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
    parameter int ALU_OP_W = 2
);
    logic [6:0]          opcode;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                i_or_d;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_write;
    logic                mem_to_reg;
    logic                illegal;
    logic                fault;
    logic [3:0]          state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               illegal, fault, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               illegal, fault, state_o
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle RISC-V control FSM. Sequences each instruction through
// FETCH / DECODE / execute / memory / write-back and drives one set of
// datapath enables per cycle. Supports R-type, LD, SD and BEQ; OP-IMM is
// optional. A watchdog halts the FSM if a memory access stalls too long.
//
// Parameters
//   ALU_OP_W  width of alu_op (>= 2); bits above [1:0] are driven 0
//   MAX_WAIT  stall cycles allowed per memory access before fault; 0 = off
//
// Ports
//   clk   system clock, all state on the rising edge
//   rst   synchronous active-high reset
//   bus   multicycle_control_unit_if.master (see interface file)
//
// Build option
//   CU_OP_IMM_EN  when defined, opcode 0010011 executes via EXEC_I;
//                 otherwise it is treated as illegal.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int ALU_OP_W = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_unit_if.master bus
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
`ifdef CU_OP_IMM_EN
    localparam logic [6:0] OP_IMM   = 7'b0010011;
`endif

    // Counter wide enough to hold MAX_WAIT; one extra bit on the compare
    // path so the increment never wraps before being matched.
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int CNT_W  = WAIT_W + 1;
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_MEM = 4'd6,
        S_WB_ALU = 4'd7,
        S_BRANCH = 4'd8,
`ifdef CU_OP_IMM_EN
        S_EXEC_I = 4'd9,
`endif
        S_HALT   = 4'd15
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              fault_q, fault_d;

    logic              mem_state;
    logic [CNT_W-1:0]  wait_next_cnt;
    logic              wd_expire;

    logic              mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
    logic              reg_write, mem_to_reg;
    logic [1:0]        alu_src_a, alu_src_b, alu_op2;

    // Watchdog: wait_q counts stall cycles already spent on the current
    // access. Expiry fires on the stall cycle that would bring the count to
    // MAX_WAIT; a mem_ready in that same cycle wins because expiry requires
    // mem_ready=0.
    assign mem_state     = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                           (state_q == S_MEM_WR);
    assign wait_next_cnt = {1'b0, wait_q} + CNT_W'(1);
    assign wd_expire     = (MAX_WAIT != 0) && mem_state && !bus.mem_ready &&
                           (wait_next_cnt == MAX_WAIT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        illegal_d  = illegal_q;
        fault_d    = fault_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op2    = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;

        // Any stall cycle in a memory state advances the counter; every other
        // cycle (completion, non-memory state) leaves it cleared, which makes
        // it zero on entry to the next memory state.
        if (mem_state && !bus.mem_ready && (MAX_WAIT != 0)) begin
            wait_d = wait_next_cnt[WAIT_W-1:0];
        end

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;                 // PC + 4
                if (wd_expire) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b10;                 // old PC + imm -> ALUOut
                alu_src_b = 2'b10;
                case (bus.opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_LOAD, OP_STORE:  state_d = S_ADDR;
                    OP_BEQ:             state_d = S_BRANCH;
`ifdef CU_OP_IMM_EN
                    OP_IMM:             state_d = S_EXEC_I;
`endif
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b00;
                alu_op2   = 2'b10;
                state_d   = S_WB_ALU;
            end
`ifdef CU_OP_IMM_EN
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op2   = 2'b11;
                state_d   = S_WB_ALU;
            end
`endif
            S_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (wd_expire) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (wd_expire) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b00;
                alu_op2   = 2'b01;                 // A - B sets zero
                pc_src    = 1'b1;
                pc_write  = bus.zero;              // taken only when equal
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;                  // only rst leaves HALT
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.i_or_d     = i_or_d;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = ALU_OP_W'(alu_op2);
    assign bus.reg_write  = reg_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.illegal    = illegal_q;
    assign bus.fault      = fault_q;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed and random instruction streams. For each instruction a reference
// trace (expected state and mem_ready per cycle) is built from the
// instruction class, the memory wait counts and the latency rules; every
// cycle the observed state, datapath controls and sticky flags are compared
// against a table of the per-state control values.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int ALU_OP_W = 3;
    localparam int MAX_WAIT = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALU_OP_W(ALU_OP_W)) bus ();

    multicycle_control_unit #(
        .ALU_OP_W (ALU_OP_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         st_q[$];
    bit         rdy_q[$];
    int         halt_cause;     // 0 none, 1 illegal, 2 watchdog
    int         halt_extra;
    int         force_z;        // -1 random, else forced zero value
    logic [6:0] cur_op;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Control values each state must drive, straight from the state table.
    function automatic logic [14:0] exp_out(int st, bit rdy, bit z);
        logic       mreq = 0, we = 0, iod = 0, irw = 0, pcw = 0, pcs = 0;
        logic       rw = 0, m2r = 0;
        logic [1:0] a = 2'b00, b = 2'b00;
        logic [2:0] op = 3'b000;
        case (st)
            0:  begin mreq = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin a = 2'b10; b = 2'b10; end
            2:  begin a = 2'b01; b = 2'b00; op = 3'b010; end
            3:  begin a = 2'b01; b = 2'b10; end
            4:  begin mreq = 1; iod = 1; end
            5:  begin mreq = 1; we = 1; iod = 1; end
            6:  begin rw = 1; m2r = 1; end
            7:  begin rw = 1; end
            8:  begin a = 2'b01; b = 2'b00; op = 3'b001; pcs = 1; pcw = z; end
            9:  begin a = 2'b01; b = 2'b10; op = 3'b011; end
            default: ;
        endcase
        return {mreq, we, iod, irw, pcw, pcs, a, b, op, rw, m2r};
    endfunction

    task automatic push(int st, bit rdy);
        st_q.push_back(st);
        rdy_q.push_back(rdy);
    endtask

    // A memory phase: `waits` stall cycles then completion, unless the
    // watchdog allowance is used up first.
    task automatic add_mem(int st, int waits, output bit halted);
        halted = 1'b0;
        if (waits >= MAX_WAIT) begin
            repeat (MAX_WAIT) push(st, 1'b0);
            push(15, 1'($urandom_range(0, 1)));
            halt_cause = 2;
            halted     = 1'b1;
        end else begin
            repeat (waits) push(st, 1'b0);
            push(st, 1'b1);
        end
    endtask

    task automatic build(logic [6:0] op, int fw, int mw);
        bit h;
        st_q.delete();
        rdy_q.delete();
        halt_cause = 0;
        cur_op     = op;
        add_mem(0, fw, h);
        if (!h) begin
            push(1, 1'($urandom_range(0, 1)));
            case (op)
                OP_R:   begin push(2, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
                OP_LD:  begin
                    push(3, 1'($urandom_range(0, 1)));
                    add_mem(4, mw, h);
                    if (!h) push(6, 1'($urandom_range(0, 1)));
                end
                OP_SD:  begin push(3, 1'($urandom_range(0, 1))); add_mem(5, mw, h); end
                OP_BEQ: push(8, 1'($urandom_range(0, 1)));
`ifdef CU_OP_IMM_EN
                OP_IMM: begin push(9, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
`endif
                default: begin push(15, 1'($urandom_range(0, 1))); halt_cause = 1; end
            endcase
        end
        // Once halted, later mem_ready pulses must change nothing.
        if (halt_cause != 0) repeat (halt_extra) push(15, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("reset state", 32'(bus.state_o), 32'd0);
        chk("reset illegal", 32'(bus.illegal), 32'd0);
        chk("reset fault", 32'(bus.fault), 32'd0);
        chk("reset mem_req", 32'(bus.mem_req), 32'd1);
        chk("reset i_or_d", 32'(bus.i_or_d), 32'd0);
        chk("reset outputs", 32'({bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write,
            bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.reg_write, bus.mem_to_reg}), 32'(exp_out(0, 1'b0, 1'b0)));
    endtask

    task automatic run(string name);
        int   n = st_q.size();
        bit   z;
        logic [14:0] got;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst           = 1'b0;
            z             = (force_z < 0) ? 1'($urandom_range(0, 1)) : force_z[0];
            bus.zero      = z;
            bus.mem_ready = rdy_q[i];
            bus.opcode    = (st_q[i] == 0) ? 7'($urandom) : cur_op;
            #1;
            got = {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.pc_write,
                   bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                   bus.reg_write, bus.mem_to_reg};
            chk($sformatf("%s state c%0d", name, i), 32'(bus.state_o), 32'(st_q[i]));
            chk($sformatf("%s outputs c%0d", name, i), 32'(got), 32'(exp_out(st_q[i], rdy_q[i], z)));
            chk($sformatf("%s illegal c%0d", name, i), 32'(bus.illegal),
                32'((st_q[i] == 15) && (halt_cause == 1)));
            chk($sformatf("%s fault c%0d", name, i), 32'(bus.fault),
                32'((st_q[i] == 15) && (halt_cause == 2)));
        end
        $display("[TB] %s op=%b cycles=%0d halt_cause=%0d", name, cur_op, n, halt_cause);
        if (halt_cause != 0) do_reset();
    endtask

    initial begin
        logic [6:0] ops[6];
        logic [6:0] op;
        int         fw, mw;
        bus.opcode    = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        force_z       = -1;
        halt_extra    = 3;
        ops[0] = OP_R; ops[1] = OP_LD; ops[2] = OP_SD;
        ops[3] = OP_BEQ; ops[4] = OP_IMM; ops[5] = 7'h7F;

        do_reset();

        build(OP_R, 0, 0);             run("rtype");
        build(OP_LD, 0, 3);            run("ld_3wait");
        build(OP_SD, 0, 0);            run("sd");
        force_z = 1; build(OP_BEQ, 0, 0); run("beq_taken");
        force_z = 0; build(OP_BEQ, 0, 0); run("beq_not_taken");
        force_z = -1;

        halt_extra = 20;
        build(OP_IMM, 0, 0);           run("opimm");
        build(7'h7F, 1, 0);            run("illegal_hold");
        halt_extra = 3;

        build(OP_R, MAX_WAIT, 0);              run("wd_fetch");
        build(OP_SD, 0, MAX_WAIT);             run("wd_memwr");
        build(OP_LD, 0, MAX_WAIT);             run("wd_memrd");
        build(OP_LD, MAX_WAIT - 1, MAX_WAIT - 1); run("ld_edge_wait");
        build(OP_SD, MAX_WAIT - 1, MAX_WAIT - 1); run("sd_edge_wait");

        // Reset while MEM_RD is stalled: keep FETCH, DECODE, ADDR + 2 stalls.
        build(OP_LD, 0, 3);
        while (st_q.size() > 5) begin
            void'(st_q.pop_back());
            void'(rdy_q.pop_back());
        end
        run("ld_cut");
        do_reset();

        for (int k = 0; k < 300; k++) begin
            op = ops[$urandom_range(0, 5)];
            if (op == 7'h7F) op = 7'($urandom);
            fw = ($urandom_range(0, 15) == 0) ? MAX_WAIT : $urandom_range(0, MAX_WAIT - 1);
            mw = ($urandom_range(0, 15) == 0) ? MAX_WAIT : $urandom_range(0, MAX_WAIT - 1);
            build(op, fw, mw);
            run($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
